// File: rtl/led_regs_pkg.sv
// Shared definitions for the AXI4-Lite LED register block.
//   OFF_*      : word offsets (addr[3:2]) of the four registers
//   resp_t     : AXI response codes used on B and R channels
//   byte_mask  : expands a 4-bit write strobe into a 32-bit bit mask
package led_regs_pkg;

    localparam logic [1:0] OFF_CTRL = 2'd0;
    localparam logic [1:0] OFF_STAT = 2'd1;
    localparam logic [1:0] OFF_DIV  = 2'd2;
    localparam logic [1:0] OFF_SCR  = 2'd3;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_lite_led_slave_if.sv
// AXI4-Lite bus bundle between the VIP master and the LED register block.
//   Write address : awaddr, awprot, awvalid, awready
//   Write data    : wdata, wstrb, wvalid, wready
//   Write response: bresp, bvalid, bready
//   Read address  : araddr, arprot, arvalid, arready
//   Read data     : rdata, rresp, rvalid, rready
//
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where valid and ready are both 1. Once the source raises valid it
// keeps valid and its payload unchanged until that edge. The sink may
// change ready freely; no valid ever depends combinationally on a ready.
interface axi_lite_led_slave_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,     input wready,
        input  bresp, bvalid,            output bready,
        output araddr, arprot, arvalid,  input arready,
        input  rdata, rresp, rvalid,     output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

endinterface

// File: rtl/blink_timer.sv
// Half-period timer for the LED blink feature.
//   clk, rst_n : clock, asynchronous active-low reset
//   div        : half-period in clk cycles; 0 freezes the timer
//   restart    : pulse when div is rewritten; count restarts at 0, phase=1
//   phase      : current blink phase, toggles each time count wraps
module blink_timer #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             restart,
    output logic             phase
);

    logic [DIV_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            phase   <= 1'b0;
        end else if (restart) begin
            count_q <= '0;
            phase   <= 1'b1;
        end else if (div == '0) begin
            count_q <= '0;
        end else if (count_q >= div - DIV_W'(1)) begin
            // >= rather than == so a count left above a smaller div still wraps
            count_q <= '0;
            phase   <= ~phase;
        end else begin
            count_q <= count_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/axi_lite_led_slave.sv
// AXI4-Lite responder exposing a four-word LED register file.
//   aclk, aresetn : clock, asynchronous active-low reset
//   s_axi         : AXI4-Lite slave port (see axi_lite_led_slave_if)
//   leds_o        : registered LED drive
// Register map (addr[3:2]): 0 CTRL rw, 1 STAT ro (live leds_o),
// 2 DIV rw (blink half-period, 0 = steady), 3 SCR rw scratch.
// addr[1:0] != 0 answers SLVERR without touching any register.
module axi_lite_led_slave
    import led_regs_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LED_W  = 4,
    parameter int DIV_W  = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    axi_lite_led_slave_if.slave s_axi,
    output logic [LED_W-1:0]    leds_o
);

    // Readies stay low while reset is asserted and for the first edge after.
    logic ready_en;

    // Write channel holding registers
    logic        aw_held;
    logic [3:0]  aw_addr_q;
    logic        w_held;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        bvalid_q;
    resp_t       bresp_q;

    // Read channel registers
    logic        rvalid_q;
    resp_t       rresp_q;
    logic [31:0] rdata_q;

    // Register file
    logic [LED_W-1:0] ctrl_q;
    logic [DIV_W-1:0] div_q;
    logic [31:0]      scr_q;
    logic [LED_W-1:0] leds_q;
    logic             blink_phase;

    logic awready_c, wready_c, arready_c;
    logic aw_fire, w_fire, ar_fire;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] wr_mask;
    logic        commit, wr_ok;
    logic        wr_ctrl, wr_div, wr_scr;
    logic [LED_W-1:0] ctrl_d;
    logic [DIV_W-1:0] div_d;
    logic [31:0]      scr_d;
    logic [31:0]      rd_data_c;
    resp_t            rd_resp_c;

    // Upper address bits and protection fields carry no meaning here.
    logic [ADDR_W-1:0] unused_addr;
    logic              unused_prot;
    assign unused_addr = s_axi.awaddr | s_axi.araddr;
    assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

    // ---------------- handshakes ----------------
    assign awready_c = ready_en && !aw_held && !bvalid_q;
    assign wready_c  = ready_en && !w_held  && !bvalid_q;
    assign arready_c = ready_en && !rvalid_q;

    assign aw_fire = s_axi.awvalid && awready_c;
    assign w_fire  = s_axi.wvalid  && wready_c;
    assign ar_fire = s_axi.arvalid && arready_c;

    // A write commits on the first edge where address and data are both
    // available, either from the holding registers or firing this cycle.
    assign wr_addr = aw_held ? aw_addr_q : s_axi.awaddr[3:0];
    assign wr_data = w_held  ? w_data_q  : s_axi.wdata;
    assign wr_strb = w_held  ? w_strb_q  : s_axi.wstrb;
    assign commit  = (aw_held || aw_fire) && (w_held || w_fire) && !bvalid_q;
    assign wr_ok   = commit && (wr_addr[1:0] == 2'b00);

    assign wr_ctrl = wr_ok && (wr_addr[3:2] == OFF_CTRL);
    assign wr_div  = wr_ok && (wr_addr[3:2] == OFF_DIV);
    assign wr_scr  = wr_ok && (wr_addr[3:2] == OFF_SCR);

    assign wr_mask = byte_mask(wr_strb);
    assign ctrl_d  = (ctrl_q & ~wr_mask[LED_W-1:0]) | (wr_data[LED_W-1:0] & wr_mask[LED_W-1:0]);
    assign div_d   = (div_q  & ~wr_mask[DIV_W-1:0]) | (wr_data[DIV_W-1:0] & wr_mask[DIV_W-1:0]);
    assign scr_d   = (scr_q  & ~wr_mask) | (wr_data & wr_mask);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en  <= 1'b0;
            aw_held   <= 1'b0;
            aw_addr_q <= '0;
            w_held    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            ready_en <= 1'b1;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= s_axi.awaddr[3:0];
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_axi.wdata;
                    w_strb_q <= s_axi.wstrb;
                end
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (wr_addr[1:0] == 2'b00) ? OKAY : SLVERR;
            end else if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // ---------------- read path ----------------
    // Captured from the register values before any write on the same edge.
    always_comb begin
        rd_data_c = '0;
        rd_resp_c = OKAY;
        if (s_axi.araddr[1:0] != 2'b00) begin
            rd_resp_c = SLVERR;
        end else begin
            case (s_axi.araddr[3:2])
                OFF_CTRL: rd_data_c = 32'(ctrl_q);
                OFF_STAT: rd_data_c = 32'(leds_q);
                OFF_DIV:  rd_data_c = 32'(div_q);
                OFF_SCR:  rd_data_c = scr_q;
                default:  rd_data_c = '0;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rresp_q  <= OKAY;
            rdata_q  <= '0;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_resp_c;
            rdata_q  <= rd_data_c;
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // ---------------- register file and LED drive ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl_q <= '0;
            div_q  <= '0;
            scr_q  <= '0;
            leds_q <= '0;
        end else begin
            if (wr_ctrl) ctrl_q <= ctrl_d;
            if (wr_div)  div_q  <= div_d;
            if (wr_scr)  scr_q  <= scr_d;
            leds_q <= ctrl_q & {LED_W{blink_phase || (div_q == '0)}};
        end
    end

    blink_timer #(
        .DIV_W(DIV_W)
    ) u_blink (
        .clk    (aclk),
        .rst_n  (aresetn),
        .div    (div_q),
        .restart(wr_div),
        .phase  (blink_phase)
    );

    assign s_axi.awready = awready_c;
    assign s_axi.wready  = wready_c;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_c;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign leds_o        = leds_q;

endmodule

// File: tb/tb_axi_lite_led_slave.sv
// Self-checking bench for axi_lite_led_slave: randomized AXI-Lite traffic
// against a register-level reference model held in plain variables.
module tb_axi_lite_led_slave;

    localparam int ADDR_W = 32;
    localparam int LED_W  = 4;
    localparam int DIV_W  = 32;
    localparam int TMO    = 40;
    localparam logic [31:0] BASE     = 32'hC000_0000;
    localparam logic [31:0] LED_MASK = (LED_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << LED_W) - 32'd1);
    localparam logic [31:0] DIV_MASK = (DIV_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << DIV_W) - 32'd1);

    logic             aclk;
    logic             aresetn;
    logic [LED_W-1:0] leds;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_ctrl, m_div, m_scr;

    axi_lite_led_slave_if #(.ADDR_W(ADDR_W)) bus ();

    axi_lite_led_slave #(
        .ADDR_W(ADDR_W),
        .LED_W (LED_W),
        .DIV_W (DIV_W)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .s_axi  (bus),
        .leds_o (leds)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_clear();
        m_ctrl = '0;
        m_div  = '0;
        m_scr  = '0;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] cur;
        if (addr[1:0] != 2'b00) return 2'b10;
        case (addr[3:2])
            2'd0:    cur = m_ctrl;
            2'd2:    cur = m_div;
            default: cur = m_scr;
        endcase
        for (int b = 0; b < 4; b++) if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
        case (addr[3:2])
            2'd0:    m_ctrl = cur & LED_MASK;
            2'd2:    m_div  = cur & DIV_MASK;
            2'd3:    m_scr  = cur;
            default: ;
        endcase
        return 2'b00;
    endfunction

    // {resp, data}; STAT is only read while blinking is off, so it equals CTRL
    function automatic logic [33:0] model_read(input logic [31:0] addr);
        if (addr[1:0] != 2'b00) return {2'b10, 32'h0};
        case (addr[3:2])
            2'd0:    return {2'b00, m_ctrl};
            2'd1:    return {2'b00, m_ctrl};
            2'd2:    return {2'b00, m_div};
            default: return {2'b00, m_scr};
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        bus.awaddr  = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata   = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        bus.araddr  = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
    endtask

    // Entered in the low clock phase; returns in the low phase right after
    // the B handshake edge.
    task automatic write_finish(output logic [1:0] resp);
        int   n;
        logic aw_f, w_f;
        n = 0;
        while ((bus.awvalid || bus.wvalid) && n < TMO) begin
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            @(negedge aclk);
            n++;
            if (aw_f) bus.awvalid = 1'b0;
            if (w_f)  bus.wvalid  = 1'b0;
        end
        while (!bus.bvalid && n < TMO) begin
            @(negedge aclk);
            n++;
        end
        if (n >= TMO) begin
            total++; bad++;
            $display("FAIL write_timeout: got no bvalid within %0d cycles, required bvalid=1", TMO);
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            resp = 2'bxx;
        end else begin
            resp = bus.bresp;
            bus.bready = 1'b1;
            @(negedge aclk);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata  = data; bus.wstrb   = strb; bus.wvalid = 1'b1;
        write_finish(resp);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int   n;
        logic ar_f;
        n = 0;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        while (bus.arvalid && n < TMO) begin
            ar_f = bus.arready;
            @(negedge aclk);
            n++;
            if (ar_f) bus.arvalid = 1'b0;
        end
        while (!bus.rvalid && n < TMO) begin
            @(negedge aclk);
            n++;
        end
        if (n >= TMO) begin
            total++; bad++;
            $display("FAIL read_timeout: got no rvalid within %0d cycles, required rvalid=1", TMO);
            bus.arvalid = 1'b0;
            data = 'x; resp = 2'bxx;
        end else begin
            data = bus.rdata;
            resp = bus.rresp;
            @(negedge aclk);
        end
    endtask

    task automatic apply_reset();
        bus_idle();
        aresetn = 1'b0;
        #200;
        @(negedge aclk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d; logic [1:0] r, er; logic [33:0] e;
        apply_reset();
        total++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
            bad++; $display("FAIL rst_handshake: got %b expected 00000",
                            {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
        total++;
        if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
            bad++; $display("FAIL rst_resp_data: got bresp=%b rresp=%b rdata=%h expected all 0",
                            bus.bresp, bus.rresp, bus.rdata);
        end
        total++;
        if (leds !== '0) begin bad++; $display("FAIL rst_leds: got %b expected 0", leds); end
        aresetn = 1'b1;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            axi_read(BASE + 32'(4 * i), d, r);
            e = model_read(BASE + 32'(4 * i));
            total++;
            if ({r, d} !== e) begin bad++; $display("FAIL rst_read%0d: got %b/%h expected %b/%h", i, r, d, e[33:32], e[31:0]); end
        end
        er = model_write(BASE, 32'h3, 4'hF);
        axi_write(BASE, 32'h3, 4'hF, r);
        total++;
        if (r !== er) begin bad++; $display("FAIL ctrl_bresp: got %b expected %b", r, er); end
        axi_read(BASE + 32'h4, d, r);
        total++;
        if ({r, d} !== {2'b00, 32'h3}) begin bad++; $display("FAIL stat_read: got %b/%h expected 00/00000003", r, d); end
        total++;
        if (leds !== 4'b0011) begin bad++; $display("FAIL leds_ctrl: got %b expected 0011", leds); end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d, val; logic [1:0] r, er; logic [33:0] e;
        val = $urandom;
        bus.wdata = val; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        total++;
        if (bus.wready !== 1'b1) begin bad++; $display("FAIL w_ready_idle: got %b expected 1", bus.wready); end
        @(negedge aclk);
        bus.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({bus.wready, bus.bvalid} !== 2'b00) begin
                bad++; $display("FAIL w_held%0d: got wready=%b bvalid=%b expected 0,0", i, bus.wready, bus.bvalid);
            end
            if (i < 2) @(negedge aclk);
        end
        bus.awaddr = BASE + 32'hC; bus.awvalid = 1'b1;
        total++;
        if (bus.awready !== 1'b1) begin bad++; $display("FAIL aw_ready_late: got %b expected 1", bus.awready); end
        @(negedge aclk);
        bus.awvalid = 1'b0;
        er = model_write(BASE + 32'hC, val, 4'hF);
        total++;
        if ({bus.bvalid, bus.bresp} !== {1'b1, er}) begin
            bad++; $display("FAIL b_after_aw: got bvalid=%b bresp=%b expected 1,%b", bus.bvalid, bus.bresp, er);
        end
        @(negedge aclk);
        axi_read(BASE + 32'hC, d, r);
        e = model_read(BASE + 32'hC);
        total++;
        if ({r, d} !== e) begin bad++; $display("FAIL scr_late_aw: got %b/%h expected %b/%h", r, d, e[33:32], e[31:0]); end
    endtask

    task automatic test_bready_stall();
        logic [31:0] d, a_val, c_val; logic [1:0] r, er1, er2; logic [33:0] e;
        a_val = $urandom; c_val = $urandom;
        bus.bready = 1'b0;
        bus.awaddr = BASE + 32'hC; bus.awvalid = 1'b1;
        bus.wdata = a_val; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        er1 = model_write(BASE + 32'hC, a_val, 4'hF);
        // second write presented while the first response is stalled
        bus.awaddr = BASE; bus.awvalid = 1'b1;
        bus.wdata = c_val; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== {1'b1, er1, 2'b00}) begin
                bad++; $display("FAIL stall%0d: got bvalid=%b bresp=%b awready=%b wready=%b expected 1,%b,0,0",
                                i, bus.bvalid, bus.bresp, bus.awready, bus.wready, er1);
            end
            @(negedge aclk);
        end
        bus.bready = 1'b1;
        @(negedge aclk);
        total++;
        if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL stall_release: got bvalid=%b expected 0", bus.bvalid); end
        er2 = model_write(BASE, c_val, 4'hF);
        write_finish(r);
        total++;
        if (r !== er2) begin bad++; $display("FAIL second_bresp: got %b expected %b", r, er2); end
        axi_read(BASE, d, r);
        e = model_read(BASE);
        total++;
        if ({r, d} !== e) begin bad++; $display("FAIL second_ctrl: got %b/%h expected %b/%h", r, d, e[33:32], e[31:0]); end
        axi_read(BASE + 32'hC, d, r);
        e = model_read(BASE + 32'hC);
        total++;
        if ({r, d} !== e) begin bad++; $display("FAIL first_scr: got %b/%h expected %b/%h", r, d, e[33:32], e[31:0]); end
    endtask

    task automatic test_strobe();
        logic [31:0] d, a, v; logic [3:0] s; logic [1:0] r, er; logic [33:0] e;
        er = model_write(BASE + 32'hC, 32'h0, 4'hF);
        axi_write(BASE + 32'hC, 32'h0, 4'hF, r);
        er = model_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'b0010);
        axi_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'b0010, r);
        axi_read(BASE + 32'hC, d, r);
        total++;
        if ({r, d} !== {2'b00, 32'h0000_FF00}) begin bad++; $display("FAIL strb_0010: got %b/%h expected 00/0000ff00", r, d); end
        for (int i = 0; i < 8; i++) begin
            a = ($urandom_range(0, 1) != 0) ? BASE : BASE + 32'hC;
            v = $urandom; s = 4'($urandom_range(0, 15));
            er = model_write(a, v, s);
            axi_write(a, v, s, r);
            total++;
            if (r !== er) begin bad++; $display("FAIL strb_bresp%0d: got %b expected %b", i, r, er); end
            axi_read(a, d, r);
            e = model_read(a);
            total++;
            if ({r, d} !== e) begin bad++; $display("FAIL strb_rand%0d: got %b/%h expected %b/%h", i, r, d, e[33:32], e[31:0]); end
        end
    endtask

    // write and read of SCR handshake on the same edge
    task automatic test_back_to_back();
        logic [31:0] d, v_old, v_new; logic [1:0] r, er; logic [33:0] e_old, e;
        v_old = $urandom; v_new = ~v_old;
        er = model_write(BASE + 32'hC, v_old, 4'hF);
        axi_write(BASE + 32'hC, v_old, 4'hF, r);
        e_old = model_read(BASE + 32'hC);
        bus.awaddr = BASE + 32'hC; bus.awvalid = 1'b1;
        bus.wdata = v_new; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = BASE + 32'hC; bus.arvalid = 1'b1;
        total++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            bad++; $display("FAIL same_edge_ready: got %b expected 111", {bus.awready, bus.wready, bus.arready});
        end
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        er = model_write(BASE + 32'hC, v_new, 4'hF);
        total++;
        if ({bus.rvalid, bus.rresp, bus.rdata} !== {1'b1, e_old}) begin
            bad++; $display("FAIL same_edge_read: got rvalid=%b %b/%h expected 1 %b/%h",
                            bus.rvalid, bus.rresp, bus.rdata, e_old[33:32], e_old[31:0]);
        end
        total++;
        if ({bus.bvalid, bus.bresp} !== {1'b1, er}) begin
            bad++; $display("FAIL same_edge_b: got bvalid=%b bresp=%b expected 1,%b", bus.bvalid, bus.bresp, er);
        end
        @(negedge aclk);
        axi_read(BASE + 32'hC, d, r);
        e = model_read(BASE + 32'hC);
        total++;
        if ({r, d} !== e) begin bad++; $display("FAIL same_edge_after: got %b/%h expected %b/%h", r, d, e[33:32], e[31:0]); end
    endtask

    task automatic test_blink();
        logic [31:0] c, dv, expv; logic [1:0] r, er;
        int errs;
        for (int run = 0; run < 2; run++) begin
            c  = (run == 0) ? 32'hF : 32'($urandom_range(1, 15));
            dv = (run == 0) ? 32'd4 : 32'($urandom_range(2, 6));
            er = model_write(BASE, c, 4'hF);
            axi_write(BASE, c, 4'hF, r);
            er = model_write(BASE + 32'h8, dv, 4'hF);
            axi_write(BASE + 32'h8, dv, 4'hF, r);
            total++;
            if (r !== er) begin bad++; $display("FAIL div_bresp%0d: got %b expected %b", run, r, er); end
            // phase starts at 1 on the DIV write edge and the LED register
            // follows one cycle later; sample k is k cycles after that edge
            errs = 0;
            for (int k = 1; k <= 4 * int'(dv); k++) begin
                expv = ((((k - 1) / int'(dv)) % 2) == 0) ? (m_ctrl & LED_MASK) : 32'h0;
                total++;
                if (32'(leds) !== expv) begin
                    bad++;
                    if (errs < 4) $display("FAIL blink%0d_k%0d: got %h expected %h", run, k, leds, expv);
                    errs++;
                end
                @(negedge aclk);
            end
            er = model_write(BASE + 32'h8, 32'h0, 4'hF);
            axi_write(BASE + 32'h8, 32'h0, 4'hF, r);
            for (int k = 1; k <= 10; k++) begin
                total++;
                if (32'(leds) !== m_ctrl) begin bad++; $display("FAIL steady%0d_k%0d: got %h expected %h", run, k, leds, m_ctrl); end
                @(negedge aclk);
            end
        end
    endtask

    task automatic test_slverr_reset();
        logic [31:0] d, held; logic [1:0] r, er; logic [33:0] e;
        axi_read(BASE + 32'h2, d, r);
        e = model_read(BASE + 32'h2);
        total++;
        if ({r, d} !== e) begin bad++; $display("FAIL misaligned_read: got %b/%h expected %b/%h", r, d, e[33:32], e[31:0]); end
        er = model_write(BASE, 32'h5, 4'hF);
        axi_write(BASE, 32'h5, 4'hF, r);
        er = model_write(BASE + 32'h1, 32'hFF, 4'hF);
        axi_write(BASE + 32'h1, 32'hFF, 4'hF, r);
        total++;
        if (r !== er) begin bad++; $display("FAIL misaligned_bresp: got %b expected %b", r, er); end
        axi_read(BASE, d, r);
        e = model_read(BASE);
        total++;
        if ({r, d} !== e) begin bad++; $display("FAIL misaligned_nowrite: got %b/%h expected %b/%h", r, d, e[33:32], e[31:0]); end
        // hold a read response with rready low, then reset underneath it
        bus.rready = 1'b0;
        bus.araddr = BASE + 32'hC; bus.arvalid = 1'b1;
        @(negedge aclk);
        bus.arvalid = 1'b0;
        held = bus.rdata;
        total++;
        if ({bus.rvalid, bus.rdata} !== {1'b1, m_scr}) begin
            bad++; $display("FAIL rhold: got rvalid=%b rdata=%h expected 1,%h", bus.rvalid, bus.rdata, m_scr);
        end
        @(negedge aclk);
        total++;
        if ({bus.rvalid, bus.rdata} !== {1'b1, held}) begin
            bad++; $display("FAIL rstable: got rvalid=%b rdata=%h expected 1,%h", bus.rvalid, bus.rdata, held);
        end
        #2;
        aresetn = 1'b0;
        #1;
        total++;
        if ({bus.rvalid, bus.bvalid, bus.arready, leds} !== '0) begin
            bad++; $display("FAIL async_reset: got rvalid=%b bvalid=%b arready=%b leds=%b expected all 0",
                            bus.rvalid, bus.bvalid, bus.arready, leds);
        end
        #40;
        @(negedge aclk);
        bus_idle();
        aresetn = 1'b1;
        model_clear();
        axi_read(BASE, d, r);
        total++;
        if ({r, d} !== {2'b00, 32'h0}) begin bad++; $display("FAIL ctrl_after_reset: got %b/%h expected 00/00000000", r, d); end
    endtask

    task automatic test_random();
        logic [31:0] a, v, d; logic [3:0] s; logic [1:0] r, er; logic [33:0] e;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) != 0) begin
                if (a[3:0] == 4'h8) a[3:0] = 4'hC;  // keep blinking off
                v = $urandom; s = 4'($urandom_range(0, 15));
                er = model_write(a, v, s);
                axi_write(a, v, s, r);
                total++;
                if (r !== er) begin bad++; $display("FAIL rand_wr%0d: addr=%h got %b expected %b", i, a, r, er); end
            end else begin
                e = model_read(a);
                axi_read(a, d, r);
                total++;
                if ({r, d} !== e) begin bad++; $display("FAIL rand_rd%0d: addr=%h got %b/%h expected %b/%h", i, a, r, d, e[33:32], e[31:0]); end
            end
        end
    endtask

    initial begin
        aresetn = 1'b0;
        model_clear();
        bus_idle();
        test_reset();
        test_w_before_aw();
        test_bready_stall();
        test_strobe();
        test_back_to_back();
        test_blink();
        test_slverr_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
